pc_call_ctrl: RTL and testbench
===============================

// Module: pc_call_ctrl
// PURPOSE
//  Program-counter / fetch sequencer of the TB4004 core and the initiator side of the 8-level call stack.
//  Runs the 8-phase 4004 machine cycle, drives ROM address nibbles and latches OPR/OPA.
//  Resolves one- and two-word control flow: JUN, JMS, JCN, ISZ, JIN, BBL.
//  Issues single-clock push/pop strobes to the stack and reloads PC from the popped value.
// PARAMETERS
//  PC_W      12      program counter width (4 KiB ROM space)
//  RESET_PC  12'h000 PC value after reset
// PORTS
//  clk          in   1     clock; single clock domain
//  rst          in   1     reset, asynchronous, active-high
//  cyc_en       in   1     advance one phase this clock; low = full freeze
//  rom_data     in   4     ROM nibble, sampled in M1/M2
//  cond_ok      in   1     JCN condition true (valid from X1 of word 2)
//  isz_nz       in   1     ISZ incremented register != 0 (valid from X1 of word 2)
//  jin_addr     in   8     register-pair value for JIN
//  stk_sp       in   3     current stack pointer
//  stk_pc_in    in   12    popped return address (registered by stack on pop edge)
//  stk_push     out  1     push strobe, 1 clk
//  stk_pop      out  1     pop strobe, 1 clk
//  stk_pc_out   out  12    return address to push
//  rom_addr     out  4     address nibble (A1..A3)
//  phase        out  3     A1=0 A2=1 A3=2 M1=3 M2=4 X1=5 X2=6 X3=7
//  sync         out  1     high while phase==X3
//  opr, opa     out  4,4   current instruction nibbles
//  word2        out  1     current machine cycle fetches the second word
//  pc           out  12    current PC
//  err_ovf      out  1     sticky: JMS issued with stk_sp==7
//  err_unf      out  1     sticky: BBL issued with stk_sp==0
// BEHAVIOUR
//  Reset: phase=A1, pc=RESET_PC, opr=opa=0, word2=0, stk_push=stk_pop=0, stk_pc_out=0, sync=0, err_*=0.
//  Async reset mid-cycle drops any pending two-word op; no strobe is emitted.
//  Phase advances only on clk with cyc_en=1; X3 wraps to A1.
//  rom_addr: A1=pc[3:0], A2=pc[7:4], A3=pc[11:8]; else 0.
//  M1 latches opr<=rom_data and M2 latches opa<=rom_data, in word 1 only.
//  In word 2, M1/M2 latch the 8-bit operand w2={M1,M2} (high nibble first).
//  Decode at end of M2 (word 1). Two-word ops: opr 1 (JCN), 2 with opa[0]=0 (FIM), 4 (JUN), 5 (JMS), 7 (ISZ).
//  For a two-word op, word2 is set for the next machine cycle.
//  PC update at X3 (pa = address of word 2, nx = pa+1):
//   - default / FIM / word-1 of any two-word op: pc<=pc+1
//   - JUN: pc<={opa,w2}
//   - JMS: stk_pc_out<=nx and stk_push=1 for the X3 clock; pc<={opa,w2}
//   - JCN: cond_ok ? pc<={nx[11:8],w2} : pc<=nx
//   - ISZ: isz_nz ? pc<={nx[11:8],w2} : pc<=nx
//     (page taken from nx, so word 2 at xFF jumps into the next page)
//   - JIN (opr 3, opa[0]=1): pc<={pc[11:8],jin_addr}
//     (pc = JIN's own address; PC-increment page quirk not modelled)
//   - BBL (opr C): stk_pop=1 for the X1 clock; pc<=stk_pc_in at X3
//  PC arithmetic is mod 2^PC_W (FFF+1 -> 000).
//  Push and pop never in the same clock, and at most one strobe per machine cycle.
//  Overflow: JMS with stk_sp==7 still pushes and jumps, sets err_ovf.
//  Underflow: BBL with stk_sp==0 still pops, sets err_unf, and takes stk_pc_in (stack returns 000).
//  Errors clear only on rst.
//  FIN is treated as a one-word op; its data fetch belongs to the operand path.
// STRUCTURE
//  tb4004_pkg: phase localparams (PH_A1..PH_X3) and opcode nibbles (OP_JCN, OP_FIM_SRC, OP_FIN_JIN, OP_JUN, OP_JMS, OP_ISZ, OP_BBL).
//  Sub-module cycle_timer: 3-bit phase counter with cyc_en, sync and is_x1/is_x3 decodes.
//  Decode and PC update stay in this module.
// TESTING
//  1 Reset, 16 NOP (00) cycles, cyc_en=1 -> pc=010; rom_addr sequence 0,0,0 then 1,0,0; sync once per 8 clocks.
//  2 JUN 4 23 at pc=000 -> word2=1 in cycle 2; after X3 pc=423; no strobe.
//  3 JMS 5 67 at pc=100, stk_sp=0 -> stk_push at X3 with stk_pc_out=102, pc=567.
//    Then BBL, stub returns 102 -> stk_pop at X1 only, pc=102.
//  4 JCN at 0FE, target 40:
//    - cond_ok=1 -> pc=140 (page of nx=100)
//    - cond_ok=0 -> pc=100
//  5 JMS with stk_sp=7 -> err_ovf=1, pc jumps. BBL with stk_sp=0, stk_pc_in=000 -> err_unf=1, pc=000.
//  6 rst pulse mid-X2 of JMS word 2 -> no stk_push ever; pc=000, phase=A1. Also: cyc_en=0 for 5 clocks holds all outputs.

Source files
------------

// File: rtl/tb4004_pkg.sv
// Shared phase encodings, opcode nibbles and control-flow decode for the TB4004 core.
package tb4004_pkg;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    localparam logic [3:0] OP_JCN     = 4'h1;
    localparam logic [3:0] OP_FIM_SRC = 4'h2;
    localparam logic [3:0] OP_FIN_JIN = 4'h3;
    localparam logic [3:0] OP_JUN     = 4'h4;
    localparam logic [3:0] OP_JMS     = 4'h5;
    localparam logic [3:0] OP_ISZ     = 4'h7;
    localparam logic [3:0] OP_BBL     = 4'hC;

    typedef enum logic [2:0] {
        FLOW_SEQ,
        FLOW_JUN,
        FLOW_JMS,
        FLOW_JCN,
        FLOW_ISZ,
        FLOW_JIN,
        FLOW_BBL
    } flow_e;

    // FIM (opa[0]=0) fetches a data byte as its second word; SRC shares the nibble but is one word.
    function automatic logic is_two_word(input logic [3:0] opr, input logic opa_lsb);
        case (opr)
            OP_JCN, OP_JUN, OP_JMS, OP_ISZ: return 1'b1;
            OP_FIM_SRC:                     return !opa_lsb;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic flow_e decode_flow(input logic [3:0] opr, input logic opa_lsb,
                                          input logic word2);
        flow_e f;
        f = FLOW_SEQ;
        if (word2) begin
            case (opr)
                OP_JUN:  f = FLOW_JUN;
                OP_JMS:  f = FLOW_JMS;
                OP_JCN:  f = FLOW_JCN;
                OP_ISZ:  f = FLOW_ISZ;
                default: f = FLOW_SEQ;
            endcase
        end else if (opr == OP_FIN_JIN && opa_lsb) begin
            f = FLOW_JIN;
        end else if (opr == OP_BBL) begin
            f = FLOW_BBL;
        end
        return f;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Eight-phase machine-cycle counter (A1..X3) with freeze enable and phase decodes.
module cycle_timer
    import tb4004_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cyc_en,
    output logic [2:0] o_phase,
    output logic       o_sync,
    output logic       o_is_x1,
    output logic       o_is_x3
);

    logic [2:0] r_phase;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_A1;
        end else if (i_cyc_en) begin
            r_phase <= r_phase + 3'd1;  // X3 rolls over to A1
        end
    end

    assign o_phase = r_phase;
    assign o_sync  = (r_phase == PH_X3);
    assign o_is_x1 = (r_phase == PH_X1);
    assign o_is_x3 = (r_phase == PH_X3);

endmodule

// File: rtl/pc_call_ctrl.sv
// TB4004 fetch sequencer: PC, OPR/OPA latching, one/two-word flow control and call-stack strobes.
// The three address nibbles (A1..A3) assume PC_W == 12.
module pc_call_ctrl
    import tb4004_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cyc_en,
    input  logic [3:0]      rom_data,
    input  logic            cond_ok,
    input  logic            isz_nz,
    input  logic [7:0]      jin_addr,
    input  logic [2:0]      stk_sp,
    input  logic [PC_W-1:0] stk_pc_in,
    output logic            stk_push,
    output logic            stk_pop,
    output logic [PC_W-1:0] stk_pc_out,
    output logic [3:0]      rom_addr,
    output logic [2:0]      phase,
    output logic            sync,
    output logic [3:0]      opr,
    output logic [3:0]      opa,
    output logic            word2,
    output logic [PC_W-1:0] pc,
    output logic            err_ovf,
    output logic            err_unf
);

    logic [2:0]      w_phase;
    logic            w_sync;
    logic            w_is_x1;
    logic            w_is_x3;

    logic [PC_W-1:0] r_pc;
    logic [3:0]      r_opr;
    logic [3:0]      r_opa;
    logic [7:0]      r_w2;
    logic            r_word2;
    logic [PC_W-1:0] r_stk_pc_out;
    logic            r_err_ovf;
    logic            r_err_unf;

    flow_e           w_flow;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;
    logic [3:0]      w_rom_addr;
    logic            w_push;
    logic            w_pop;

    cycle_timer u_cycle_timer (
        .clk      (clk),
        .rst      (rst),
        .i_cyc_en (cyc_en),
        .o_phase  (w_phase),
        .o_sync   (w_sync),
        .o_is_x1  (w_is_x1),
        .o_is_x3  (w_is_x3)
    );

    // OPR/OPA keep word 1 through word 2, so the decode stays valid for the whole instruction.
    assign w_flow   = decode_flow(r_opr, r_opa[0], r_word2);
    assign w_pc_inc = r_pc + PC_W'(1);

    // Strobes qualify on the advancing clock, so a frozen phase can never repeat them.
    assign w_push = cyc_en && w_is_x3 && (w_flow == FLOW_JMS);
    assign w_pop  = cyc_en && w_is_x1 && (w_flow == FLOW_BBL);

    // In word 2 r_pc already addresses word 2, so w_pc_inc is the return/fall-through address.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_pc_next = w_pc_inc;
        case (w_flow)
            FLOW_JUN, FLOW_JMS: w_pc_next = PC_W'({r_opa, r_w2});
            FLOW_JCN:           w_pc_next = cond_ok ? {w_pc_inc[PC_W-1:8], r_w2} : w_pc_inc;
            FLOW_ISZ:           w_pc_next = isz_nz  ? {w_pc_inc[PC_W-1:8], r_w2} : w_pc_inc;
            FLOW_JIN:           w_pc_next = {r_pc[PC_W-1:8], jin_addr};
            FLOW_BBL:           w_pc_next = stk_pc_in;
            default:            w_pc_next = w_pc_inc;
        endcase
    end

    always_comb begin
        w_rom_addr = 4'h0;
        case (w_phase)
            PH_A1:   w_rom_addr = r_pc[3:0];
            PH_A2:   w_rom_addr = r_pc[7:4];
            PH_A3:   w_rom_addr = r_pc[11:8];
            default: w_rom_addr = 4'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_opr        <= 4'h0;
            r_opa        <= 4'h0;
            r_w2         <= 8'h00;
            r_word2      <= 1'b0;
            r_stk_pc_out <= '0;
            r_err_ovf    <= 1'b0;
            r_err_unf    <= 1'b0;
        end else if (cyc_en) begin
            case (w_phase)
                PH_M1: begin
                    if (r_word2) r_w2[7:4] <= rom_data;
                    else         r_opr     <= rom_data;
                end
                PH_M2: begin
                    if (r_word2) r_w2[3:0] <= rom_data;
                    else         r_opa     <= rom_data;
                end
                PH_X2: begin
                    if (w_flow == FLOW_JMS) r_stk_pc_out <= w_pc_inc;
                end
                PH_X3: begin
                    r_pc    <= w_pc_next;
                    r_word2 <= !r_word2 && is_two_word(r_opr, r_opa[0]);
                end
                default: ;
            endcase

            // Overflow/underflow still complete the call/return; the flags only record it.
            if (w_push && stk_sp == 3'd7) r_err_ovf <= 1'b1;
            if (w_pop  && stk_sp == 3'd0) r_err_unf <= 1'b1;
        end
    end

    assign stk_push   = w_push;
    assign stk_pop    = w_pop;
    assign stk_pc_out = r_stk_pc_out;
    assign rom_addr   = w_rom_addr;
    assign phase      = w_phase;
    assign sync       = w_sync;
    assign opr        = r_opr;
    assign opa        = r_opa;
    assign word2      = r_word2;
    assign pc         = r_pc;
    assign err_ovf    = r_err_ovf;
    assign err_unf    = r_err_unf;

endmodule

// File: tb/tb_pc_call_ctrl.sv
// Self-checking bench for pc_call_ctrl: ROM and call-stack stubs plus an instruction-level reference model.
module tb_pc_call_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc_en = 1'b0;
    logic [3:0]  rom_data;
    logic        cond_ok = 1'b0;
    logic        isz_nz = 1'b0;
    logic [7:0]  jin_addr = 8'h00;
    logic [2:0]  stk_sp;
    logic [11:0] stk_pc_in;
    logic        stk_push, stk_pop;
    logic [11:0] stk_pc_out;
    logic [3:0]  rom_addr;
    logic [2:0]  phase;
    logic        sync;
    logic [3:0]  opr, opa;
    logic        word2;
    logic [11:0] pc;
    logic        err_ovf, err_unf;

    always #5 clk = ~clk;

    pc_call_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cyc_en     (cyc_en),
        .rom_data   (rom_data),
        .cond_ok    (cond_ok),
        .isz_nz     (isz_nz),
        .jin_addr   (jin_addr),
        .stk_sp     (stk_sp),
        .stk_pc_in  (stk_pc_in),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .stk_pc_out (stk_pc_out),
        .rom_addr   (rom_addr),
        .phase      (phase),
        .sync       (sync),
        .opr        (opr),
        .opa        (opa),
        .word2      (word2),
        .pc         (pc),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
    );

    // ROM stub: assemble the address from the A1..A3 nibbles, return high/low nibble in M1/M2.
    logic [7:0]  rom [4096];
    logic [11:0] fa = 12'h000;

    always @(negedge clk) begin
        case (phase)
            3'd0:    fa[3:0]  = rom_addr;
            3'd1:    fa[7:4]  = rom_addr;
            3'd2:    fa[11:8] = rom_addr;
            default: ;
        endcase
    end

    assign rom_data = (phase == 3'd3) ? rom[fa][7:4] : rom[fa][3:0];

    // Call-stack stub: circular on push, returns 000 and stays empty when popped at depth 0.
    logic [11:0] stub_mem [8];
    logic [2:0]  stub_sp;
    logic [11:0] stub_out;
    logic        sp_load = 1'b0;
    logic [2:0]  sp_val = 3'd0;

    assign stk_sp    = stub_sp;
    assign stk_pc_in = stub_out;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_sp  <= 3'd0;
            stub_out <= 12'h000;
        end else if (sp_load) begin
            stub_sp <= sp_val;
        end else if (stk_push) begin
            stub_mem[stub_sp] <= stk_pc_out;
            stub_sp           <= stub_sp + 3'd1;
        end else if (stk_pop) begin
            if (stub_sp == 3'd0) begin
                stub_out <= 12'h000;
            end else begin
                stub_out <= stub_mem[stub_sp - 3'd1];
                stub_sp  <= stub_sp - 3'd1;
            end
        end
    end

    // Strobe monitor.
    int          n_push = 0, n_pop = 0, n_both = 0;
    logic [11:0] push_val = 12'h000;
    logic [2:0]  push_ph = 3'd0, pop_ph = 3'd0;

    always @(negedge clk) begin
        if (stk_push) begin
            n_push++;
            push_val = stk_pc_out;
            push_ph  = phase;
        end
        if (stk_pop) begin
            n_pop++;
            pop_ph = phase;
        end
        if (stk_push && stk_pop) n_both++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level reference state.
    logic [11:0] m_pc = 12'h000;
    logic [11:0] m_stk [8];
    int          m_sp = 0;
    logic        m_ovf = 1'b0, m_unf = 1'b0;

    task automatic tick(input logic en);
        cyc_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic run_mcycle(input bit stalls);
        int adv = 0;
        int st  = 0;
        while (adv < 8) begin
            if (stalls && st < 3 && $urandom_range(0, 4) == 0) begin
                tick(1'b0);
                st++;
            end else begin
                tick(1'b1);
                adv++;
            end
        end
    endtask

    task automatic do_reset();
        cyc_en = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        m_pc  = 12'h000;
        m_sp  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic set_sp(input int n);
        sp_val  = 3'(n);
        sp_load = 1'b1;
        tick(1'b0);
        sp_load = 1'b0;
        m_sp    = n;
    endtask

    task automatic poke2(input logic [11:0] a, input logic [7:0] b0, input logic [7:0] b1);
        rom[a]              = b0;
        rom[12'(a + 12'd1)] = b1;
    endtask

    // Execute one instruction on the DUT and compare against the ISA-level rules.
    task automatic exec_instr(input bit stalls);
        logic [7:0]  b, w;
        logic [3:0]  i_opr, i_opa;
        logic [11:0] pa, nx, exp_pc, exp_val;
        bit          two;
        int          exp_push, exp_pop, p0, q0;

        b      = rom[m_pc];
        i_opr  = b[7:4];
        i_opa  = b[3:0];
        two    = (i_opr == 4'h1) || (i_opr == 4'h2 && !i_opa[0]) || (i_opr == 4'h4) ||
                 (i_opr == 4'h5) || (i_opr == 4'h7);
        pa       = m_pc + 12'd1;
        exp_pc   = pa;
        exp_val  = 12'h000;
        exp_push = 0;
        exp_pop  = 0;
        if (two) begin
            w      = rom[pa];
            nx     = pa + 12'd1;
            exp_pc = nx;
            case (i_opr)
                4'h4: exp_pc = {i_opa, w};
                4'h5: begin
                    exp_pc   = {i_opa, w};
                    exp_push = 1;
                    exp_val  = nx;
                    if (m_sp == 7) m_ovf = 1'b1;
                    m_stk[m_sp] = nx;
                    m_sp = (m_sp + 1) % 8;
                end
                4'h1: if (cond_ok) exp_pc = {nx[11:8], w};
                4'h7: if (isz_nz)  exp_pc = {nx[11:8], w};
                default: ;
            endcase
        end else if (i_opr == 4'h3 && i_opa[0]) begin
            exp_pc = {m_pc[11:8], jin_addr};
        end else if (i_opr == 4'hC) begin
            exp_pop = 1;
            if (m_sp == 0) begin
                m_unf  = 1'b1;
                exp_pc = 12'h000;
            end else begin
                m_sp   = m_sp - 1;
                exp_pc = m_stk[m_sp];
            end
        end

        p0 = n_push;
        q0 = n_pop;
        run_mcycle(stalls);
        if (two) begin
            check("word2_set", word2, 1);
            check("pc_after_word1", pc, pa);
            run_mcycle(stalls);
        end
        check("pc", pc, exp_pc);
        check("word2_clear", word2, 0);
        check("push_count", n_push - p0, exp_push);
        check("pop_count", n_pop - q0, exp_pop);
        if (exp_push == 1) begin
            check("push_value", push_val, exp_val);
            check("push_phase", push_ph, 7);
        end
        if (exp_pop == 1) check("pop_phase", pop_ph, 5);
        check("err_ovf", err_ovf, m_ovf);
        check("err_unf", err_unf, m_unf);
        m_pc = exp_pc;
    endtask

    task automatic goto_pc(input logic [11:0] a);
        poke2(m_pc, {4'h4, a[11:8]}, a[7:0]);
        exec_instr(1'b0);
    endtask

    initial begin
        int          nsync;
        int          p0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;

        // Reset state.
        do_reset();
        check("rst_phase", phase, 0);
        check("rst_pc", pc, 12'h000);
        check("rst_opr", opr, 0);
        check("rst_opa", opa, 0);
        check("rst_word2", word2, 0);
        check("rst_push", stk_push, 0);
        check("rst_pop", stk_pop, 0);
        check("rst_stk_pc_out", stk_pc_out, 0);
        check("rst_sync", sync, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_err_unf", err_unf, 0);

        // 16 NOP machine cycles.
        nsync = 0;
        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < 8; p++) begin
                if (c < 2 && p < 3)
                    check($sformatf("rom_addr_c%0d_p%0d", c, p), rom_addr, (p == 0) ? c : 0);
                if (sync) begin
                    nsync++;
                    check("sync_at_x3", phase, 7);
                end
                tick(1'b1);
            end
        end
        check("nop_sync_count", nsync, 16);
        check("nop_pc", pc, 12'h010);
        check("nop_no_strobes", n_push + n_pop, 0);

        // JUN 4 23 from 000.
        do_reset();
        poke2(12'h000, 8'h44, 8'h23);
        exec_instr(1'b0);
        check("jun_pc", pc, 12'h423);

        // JMS 5 67 at 100, then BBL back to 102.
        goto_pc(12'h100);
        poke2(12'h100, 8'h55, 8'h67);
        exec_instr(1'b0);
        check("jms_pc", pc, 12'h567);
        check("jms_ret_addr", stk_pc_out, 12'h102);
        rom[12'h567] = 8'hC0;
        exec_instr(1'b0);
        check("bbl_pc", pc, 12'h102);

        // JCN at 0FE, word 2 at 0FF: taken target uses the page of 100.
        goto_pc(12'h0FE);
        poke2(12'h0FE, 8'h14, 8'h40);
        cond_ok = 1'b1;
        exec_instr(1'b0);
        check("jcn_taken_pc", pc, 12'h140);
        goto_pc(12'h0FE);
        cond_ok = 1'b0;
        exec_instr(1'b0);
        check("jcn_not_taken_pc", pc, 12'h100);

        // ISZ across a page, then JIN and FIM.
        goto_pc(12'h2FE);
        poke2(12'h2FE, 8'h73, 8'h10);
        isz_nz = 1'b1;
        exec_instr(1'b0);
        check("isz_taken_pc", pc, 12'h310);
        rom[12'h310] = 8'h31;
        jin_addr = 8'h3C;
        exec_instr(1'b0);
        check("jin_pc", pc, 12'h33C);
        poke2(12'h33C, 8'h20, 8'h55);
        exec_instr(1'b0);
        check("fim_pc", pc, 12'h33E);

        // Overflow on JMS at depth 7, underflow on BBL at depth 0.
        set_sp(7);
        poke2(m_pc, 8'h5A, 8'hBC);
        exec_instr(1'b0);
        check("ovf_pc", pc, 12'hABC);
        check("ovf_flag", err_ovf, 1);
        set_sp(0);
        rom[12'hABC] = 8'hC3;
        exec_instr(1'b0);
        check("unf_pc", pc, 12'h000);
        check("unf_flag", err_unf, 1);

        // Freeze in M1, then reset in X2 of a JMS second word.
        do_reset();
        check("rst_clears_ovf", err_ovf, 0);
        rom[12'h000] = 8'h00;
        poke2(12'h001, 8'h52, 8'h34);
        repeat (3) tick(1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0);
            check("freeze_phase", phase, 3);
            check("freeze_pc", pc, 0);
            check("freeze_sync", sync, 0);
            check("freeze_rom_addr", rom_addr, 0);
        end
        p0 = n_push;
        repeat (5) tick(1'b1);
        check("after_freeze_pc", pc, 12'h001);
        repeat (8) tick(1'b1);
        check("jms_word2_pending", word2, 1);
        repeat (6) tick(1'b1);
        check("at_x2", phase, 6);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        check("midrst_pc", pc, 12'h000);
        check("midrst_phase", phase, 0);
        check("midrst_word2", word2, 0);
        @(posedge clk);
        #1;
        m_pc = 12'h000; m_sp = 0; m_ovf = 1'b0; m_unf = 1'b0;
        repeat (8) tick(1'b1);
        check("midrst_no_push", n_push - p0, 0);
        check("midrst_resume_pc", pc, 12'h001);

        // Randomized programs with random stalls and condition inputs.
        do_reset();
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        for (int n = 0; n < 400; n++) begin
            cond_ok  = 1'($urandom);
            isz_nz   = 1'($urandom);
            jin_addr = 8'($urandom);
            exec_instr(1'b1);
        end
        check("never_push_and_pop", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
